// File: rtl/vscale_csr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vscale_csr_arbiter_pkg                                           |
// | Brief   : Shared CSR constants and arbiter state encodings.                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package vscale_csr_arbiter_pkg;

    localparam int CSR_ADDR_WIDTH = 12;
    localparam int CSR_CMD_WIDTH  = 3;
    localparam int XPR_LEN        = 32;

    localparam logic [CSR_CMD_WIDTH-1:0] CSR_IDLE  = 3'd0;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_READ  = 3'd4;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE = 3'd5;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_SET   = 3'd6;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_CLEAR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } arb_state_e;

    // WRITE/SET/CLEAR all carry a non-zero low command field; READ does not.
    function automatic logic csr_cmd_writes(input logic [CSR_CMD_WIDTH-1:0] cmd);
        return cmd[1:0] != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vscale_csr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vscale_csr_arbiter_if                                            |
// | Brief   : Host/debug request and response channel of the CSR arbiter.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface vscale_csr_arbiter_if;
    import vscale_csr_arbiter_pkg::*;

    logic                      host_req_valid;
    logic                      host_req_ready;
    logic [CSR_ADDR_WIDTH-1:0] host_addr;
    logic [CSR_CMD_WIDTH-1:0]  host_cmd;
    logic [XPR_LEN-1:0]        host_wdata;
    logic                      host_resp_valid;
    logic                      host_resp_ready;
    logic [XPR_LEN-1:0]        host_resp_rdata;
    logic                      host_resp_err;

    modport master (
        output host_req_valid,
        input  host_req_ready,
        output host_addr,
        output host_cmd,
        output host_wdata,
        input  host_resp_valid,
        output host_resp_ready,
        input  host_resp_rdata,
        input  host_resp_err
    );

    modport slave (
        input  host_req_valid,
        output host_req_ready,
        input  host_addr,
        input  host_cmd,
        input  host_wdata,
        output host_resp_valid,
        input  host_resp_ready,
        output host_resp_rdata,
        output host_resp_err
    );

endinterface
`default_nettype wire

// File: rtl/vscale_csr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vscale_csr_arbiter                                               |
// | Brief   : Shares the CSR-file port between the core (zero-latency pass-    |
// |           through) and a buffered host requester with bounded wait.        |
// |           Macro VSCALE_CSR_ARB_HOST_WRITE_EN enables host WRITE/SET/CLEAR. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module vscale_csr_arbiter
    import vscale_csr_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      core_req_valid,
    input  logic [CSR_ADDR_WIDTH-1:0] core_addr,
    input  logic [CSR_CMD_WIDTH-1:0]  core_cmd,
    input  logic [XPR_LEN-1:0]        core_wdata,
    input  logic                      core_trap,
    output logic                      core_stall,
    output logic [XPR_LEN-1:0]        core_rdata,
    output logic                      core_illegal,

    vscale_csr_arbiter_if.slave       host,

    output logic                      csr_req,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    output logic [CSR_CMD_WIDTH-1:0]  csr_cmd,
    output logic [XPR_LEN-1:0]        csr_wdata,
    input  logic [XPR_LEN-1:0]        csr_rdata,
    input  logic                      csr_illegal
);

    localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);

    if (MAX_WAIT < 1 || MAX_WAIT > (2**WAIT_W) - 1) begin : g_param_check
        $error("vscale_csr_arbiter: MAX_WAIT out of range for WAIT_W");
    end

    arb_state_e                r_state;
    arb_state_e                w_state_nxt;
    logic [WAIT_W-1:0]         r_cnt;
    logic [WAIT_W-1:0]         w_cnt_nxt;
    logic [CSR_ADDR_WIDTH-1:0] r_buf_addr;
    logic [CSR_ADDR_WIDTH-1:0] w_buf_addr_nxt;
    logic [CSR_CMD_WIDTH-1:0]  r_buf_cmd;
    logic [CSR_CMD_WIDTH-1:0]  w_buf_cmd_nxt;
    logic [XPR_LEN-1:0]        r_buf_wdata;
    logic [XPR_LEN-1:0]        w_buf_wdata_nxt;
    logic [XPR_LEN-1:0]        r_resp_rdata;
    logic [XPR_LEN-1:0]        w_resp_rdata_nxt;
    logic                      r_resp_err;
    logic                      w_resp_err_nxt;
    logic                      w_grant;
    logic                      w_reject;

    // Commands that can never be issued are answered without touching the CSR file.
`ifdef VSCALE_CSR_ARB_HOST_WRITE_EN
    assign w_reject = (host.host_cmd == CSR_IDLE);
`else
    assign w_reject = (host.host_cmd == CSR_IDLE) || csr_cmd_writes(host.host_cmd);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_buf_addr   <= '0;
            r_buf_cmd    <= '0;
            r_buf_wdata  <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_buf_addr   <= w_buf_addr_nxt;
            r_buf_cmd    <= w_buf_cmd_nxt;
            r_buf_wdata  <= w_buf_wdata_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_buf_addr_nxt   = r_buf_addr;
        w_buf_cmd_nxt    = r_buf_cmd;
        w_buf_wdata_nxt  = r_buf_wdata;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        w_grant          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (host.host_req_valid) begin
                    w_buf_addr_nxt  = host.host_addr;
                    w_buf_cmd_nxt   = host.host_cmd;
                    w_buf_wdata_nxt = host.host_wdata;
                    w_cnt_nxt       = '0;
                    if (w_reject) begin
                        w_resp_rdata_nxt = '0;
                        w_resp_err_nxt   = 1'b1;
                        w_state_nxt      = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                // Never grant in a trap cycle so host writes cannot race trap-state updates.
                w_grant = !core_trap && (!core_req_valid || (r_cnt == c_max_wait));
                if (w_grant) begin
                    w_resp_rdata_nxt = csr_rdata;
                    w_resp_err_nxt   = csr_illegal;
                    w_state_nxt      = S_RESP;
                end else if (!core_trap && (r_cnt != c_max_wait)) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_RESP: begin
                if (host.host_resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        csr_req   = core_req_valid;
        csr_addr  = core_addr;
        csr_cmd   = core_cmd;
        csr_wdata = core_wdata;
        if (w_grant) begin
            csr_req   = 1'b1;
            csr_addr  = r_buf_addr;
            csr_cmd   = r_buf_cmd;
            csr_wdata = r_buf_wdata;
        end
    end

    assign core_stall   = w_grant && core_req_valid;
    assign core_rdata   = csr_rdata;
    assign core_illegal = csr_illegal && !core_stall;

    assign host.host_req_ready  = (r_state == S_IDLE);
    assign host.host_resp_valid = (r_state == S_RESP);
    assign host.host_resp_rdata = r_resp_rdata;
    assign host.host_resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: doc/vscale_csr_arbiter.md
Name: vscale_csr_arbiter

Overview:
- Shares the single CSR-file access port between the core pipeline (primary requester) and a host/debug requester.
- Core accesses pass through combinationally with zero added latency.
- Host requests are buffered, issued in a core-idle slot or forced after a bounded wait by stalling the core, and answered through a registered valid/ready response.
- Sits between the pipeline control, the debug transport and the CSR file.

Parameters:
- MAX_WAIT, 8, cycles a buffered host request may wait before the core is stalled to force a host slot (1..2^WAIT_W-1).
- WAIT_W, 4, width of the host wait counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- core_req_valid  in  1  core CSR access this cycle (cmd != CSR_IDLE)
- core_addr  in  CSR_ADDR_WIDTH  core CSR address
- core_cmd  in  CSR_CMD_WIDTH  core CSR command
- core_wdata  in  XPR_LEN  core write data
- core_trap  in  1  exception, mret or interrupt_taken this cycle
- core_stall  out  1  core must hold its CSR instruction this cycle
- core_rdata  out  XPR_LEN  CSR read data to core (= csr_rdata)
- core_illegal  out  1  illegal access to core (= csr_illegal & !core_stall)
- host_req_valid  in  1  host request valid
- host_req_ready  out  1  host request accepted
- host_addr  in  CSR_ADDR_WIDTH  host CSR address
- host_cmd  in  CSR_CMD_WIDTH  host command (READ/WRITE/SET/CLEAR)
- host_wdata  in  XPR_LEN  host write data
- host_resp_valid  out  1  host response valid
- host_resp_ready  in  1  host consumes response
- host_resp_rdata  out  XPR_LEN  pre-modification CSR value
- host_resp_err  out  1  access illegal or rejected
- csr_req  out  1  to CSR file req
- csr_addr  out  CSR_ADDR_WIDTH  to CSR file addr
- csr_cmd  out  CSR_CMD_WIDTH  to CSR file cmd
- csr_wdata  out  XPR_LEN  to CSR file wdata
- csr_rdata  in  XPR_LEN  from CSR file rdata
- csr_illegal  in  1  from CSR file illegal_access

Behaviour:
- Clock and reset: one clock clk; reset_n asynchronous, active-low.
- Reset state and outputs: state S_IDLE, wait counter 0, request buffer 0, host_resp_valid 0, host_resp_rdata 0, host_resp_err 0, core_stall 0.
- Reset mid-operation: discards any buffered request or pending response; no response is ever issued for it.
- S_IDLE:
  - host_req_ready=1.
  - On host_req_valid: capture addr/cmd/wdata, clear counter, go to S_WAIT.
  - Capturing a host_cmd of CSR_IDLE instead goes straight to S_RESP with err=1, rdata=0 and no CSR access.
- S_WAIT:
  - host_req_ready=0.
  - grant = !core_trap & (!core_req_valid | cnt==MAX_WAIT).
  - On grant: csr_* driven from buffer with csr_req=1, and core_stall=core_req_valid.
  - At the granting edge: host_resp_rdata<=csr_rdata, host_resp_err<=csr_illegal, go to S_RESP.
  - No grant: cnt increments, saturating at MAX_WAIT. It does not increment in a core_trap cycle.
- S_RESP:
  - host_resp_valid=1, data held stable.
  - On host_resp_ready go to S_IDLE; the next request can be accepted one cycle later.
- Non-grant cycles: csr_req=core_req_valid, csr_addr/cmd/wdata=core_*, core_stall=0.
- core_trap cycle: the host is never granted, even when cnt==MAX_WAIT, so host writes never coincide with trap-state updates in the CSR file. The force is retried on the next non-trap cycle.
- core_stall is combinational from state, cnt, core_req_valid and core_trap. It is never asserted outside S_WAIT and is at most 1 cycle per host request.
- Boundary timing: a host request accepted while the core is idle and untrapped is issued on the next cycle, and host_resp_valid rises the cycle after that.

Optional Feature:
- Macro: VSCALE_CSR_ARB_HOST_WRITE_EN.
- Defined: host WRITE/SET/CLEAR are forwarded to the CSR file.
- Undefined: host commands with cmd[1:0]!=0 are never issued. They go S_IDLE -> S_RESP directly with err=1, rdata=0, and the wait counter is unused. Host reads behave as normal.

Decomposition:
- Shared constants, reused from the existing headers: CSR_CMD_WIDTH, CSR_ADDR_WIDTH, XPR_LEN, CSR_IDLE/READ/WRITE/SET/CLEAR.
- New constants to add to the control constants header: arbiter state encodings S_IDLE/S_WAIT/S_RESP (2-bit).
- No sub-module; the wait counter and response register stay inline.

Test Plan:
- Core idle; host READ of MSCRATCH (=0x1234) -> host_resp_valid in cycle 2 after acceptance, rdata=0x1234, err=0, core_stall never asserted.
- Core issuing CSR accesses every cycle; host WRITE MSCRATCH=0xA5A5 -> core_stall high exactly in the 9th S_WAIT cycle (cnt==8); MSCRATCH then reads 0xA5A5 and the core access completes in the following cycle.
- Force cycle coinciding with core_trap=1 -> no grant, no stall that cycle; grant occurs on the next cycle with core_trap=0.
- Host WRITE to read-only MVENDORID (addr[11:10]=11) -> err=1, CSR value unchanged.
- host_resp_ready held low 5 cycles -> response stable, host_req_ready=0 throughout; a new request is accepted one cycle after the handshake.
- reset_n asserted mid-S_WAIT -> outputs return to reset values immediately, no response issued; with VSCALE_CSR_ARB_HOST_WRITE_EN undefined, host SET -> err=1, no csr_req pulse.
